divisor_varredura: RTL
======================

Name: divisor_varredura

Overview:
- Synchronous, parametrised successor to the ripple toggle-flip-flop clock divider.
- Runs entirely on one system clock and generates single-cycle enable ticks instead of derived clocks.
- Provides a runtime-programmable row-scan divisor, a row selector that wraps at any count (not only powers of two), and an image selector with a configurable number of images and dwell frames.
- Adds a post-row-change blanking window. It feeds the LED matrix row driver and image ROM selector.

Parameters:
- DIV_WIDTH, 24: width of the row divisor register and prescaler counter.
- ROW_DIV, 65536: reset value of the row divisor, in clock cycles per row. Must be ≥2.
- ROWS, 8: number of matrix rows scanned; ≥2. RW = max(1, clog2(ROWS)).
- FRAMES_PER_IMAGE, 64: complete row scans per image step; ≥1.
- N_IMAGES, 2: number of images cycled; ≥2. IW = max(1, clog2(N_IMAGES)).
- BLANK_CYCLES, 4: length of the blank pulse after each row change; 0 disables blanking.

Ports:
- clock, in, 1: system clock (50 MHz); all logic is on the rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- enable, in, 1: run/freeze control.
- div_load, in, 1: single-cycle strobe that loads div_in.
- div_in, in, DIV_WIDTH: new row divisor.
- row_tick, out, 1: one-cycle pulse at the end of each row period.
- frame_tick, out, 1: one-cycle pulse at the end of the last row.
- image_tick, out, 1: one-cycle pulse at the end of the last frame of an image.
- Seletor_Linhas, out, RW: current row index, 0..ROWS-1.
- Seletor_imagem, out, IW: current image index, 0..N_IMAGES-1.
- blank, out, 1: row-driver blanking.

Behaviour:
- Reset: sampled on a clock edge while reset_n=0, and it overrides every other input. After reset:
  - prescaler=0, row_div=ROW_DIV, Seletor_Linhas=0, frame_cnt=0, Seletor_imagem=0;
  - blank=0, blank_cnt=0, all ticks=0.
  - Reset mid-operation discards all state with no partial tick.
- Prescaler:
  - Counts 0..row_div-1 while enable=1.
  - row_tick is combinational and is 1 when enable=1, prescaler==row_div-1 and div_load=0.
  - On row_tick the prescaler wraps to 0. Tick period is row_div cycles.
- Divisor load:
  - When div_load=1: row_div <= max(div_in, 2) and prescaler <= 0 on the same edge.
  - There is no row_tick in the load cycle, even if the count is terminal (load wins).
  - Load is honoured regardless of enable.
  - The first tick after a load occurs new_div cycles after the load edge, provided enable stays 1.
- Row selector:
  - On the edge where row_tick=1, Seletor_Linhas <= (Seletor_Linhas==ROWS-1) ? 0 : Seletor_Linhas+1. The change is registered and visible the cycle after row_tick.
  - frame_tick = row_tick AND Seletor_Linhas==ROWS-1.
- Image selector:
  - frame_cnt counts 0..FRAMES_PER_IMAGE-1 on each frame_tick.
  - image_tick = frame_tick AND frame_cnt==FRAMES_PER_IMAGE-1.
  - On image_tick, frame_cnt <= 0 and Seletor_imagem increments modulo N_IMAGES.
- Blanking:
  - On each row_tick, blank_cnt <= BLANK_CYCLES. Otherwise blank_cnt decrements while enable=1 and blank_cnt>0.
  - blank = (blank_cnt != 0), registered. It therefore rises together with the Seletor_Linhas change and lasts BLANK_CYCLES cycles.
  - If row_div ≤ BLANK_CYCLES, blank stays permanently 1 after the first row_tick.
  - With BLANK_CYCLES=0, blank is constantly 0.
- Freeze: while enable=0, the prescaler, selectors, frame_cnt and blank_cnt hold and all ticks are 0. Resuming continues from the held count with no lost or extra tick.
- Nesting: row_tick, frame_tick and image_tick coincide in the same cycle at a full image wrap.

Test Plan:
- Params DIV=4, ROWS=3, FRAMES=2, N_IMAGES=3, BLANK=1; release reset with enable=1 -> row_tick every 4th cycle. Seletor_Linhas sequence 0,1,2,0. frame_tick on every 3rd row_tick. image_tick on every 6th row_tick. Seletor_imagem 0,1,2,0 after 18 row_ticks.
- Same params -> blank=1 for exactly 1 cycle, coincident with each Seletor_Linhas change; blank=0 at all other times.
- Assert div_load with div_in=6 on the cycle the prescaler is at 3 -> no row_tick that cycle; next row_tick exactly 6 cycles later, then every 6 cycles.
- div_in=0 and div_in=1 -> divisor clamped to 2; row_tick every 2 cycles. With BLANK=2 -> blank stuck at 1.
- Drop enable for 10 cycles with the prescaler at 2 -> no ticks and all outputs held; the first row_tick comes 2 cycles after enable returns.
- Assert reset_n=0 for one edge mid-frame (row 2, image 1) -> all outputs 0 the next cycle and the scan restarts from row 0, image 0 with a full ROW_DIV period.

Source files
------------

// File: rtl/divisor_varredura.sv
// divisor_varredura: single-clock row/frame/image scan timing for an LED matrix.
// A programmable prescaler produces one-cycle row ticks; row, frame and image
// counters nest on those ticks, and a short blanking window follows each row change.
// Tick semantics: row_tick, frame_tick and image_tick are combinational,
// one-cycle enables. They are only ever 1 while enable=1 and div_load=0. The
// counters they advance change on the same clock edge, so the new row or image
// index is visible from the following cycle onward.
module divisor_varredura #(
  parameter int DIV_WIDTH        = 24,
  parameter int ROW_DIV          = 65536,
  parameter int ROWS             = 8,
  parameter int FRAMES_PER_IMAGE = 64,
  parameter int N_IMAGES         = 2,
  parameter int BLANK_CYCLES     = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int IW = (N_IMAGES > 1) ? $clog2(N_IMAGES) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 row_tick,
  output logic                 frame_tick,
  output logic                 image_tick,
  output logic [RW-1:0]        Seletor_Linhas,
  output logic [IW-1:0]        Seletor_imagem,
  output logic                 blank
);

  localparam int FW = (FRAMES_PER_IMAGE > 1) ? $clog2(FRAMES_PER_IMAGE) : 1;
  localparam int BW = ($clog2(BLANK_CYCLES + 1) > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [DIV_WIDTH-1:0] DIV_RST    = DIV_WIDTH'(ROW_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN    = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);
  localparam logic [RW-1:0]        ROW_LAST   = RW'(ROWS - 1);
  localparam logic [FW-1:0]        FRAME_LAST = FW'(FRAMES_PER_IMAGE - 1);
  localparam logic [IW-1:0]        IMG_LAST   = IW'(N_IMAGES - 1);
  localparam logic [BW-1:0]        BLANK_INIT = BW'(BLANK_CYCLES);

  logic [DIV_WIDTH-1:0] prescaler;
  logic [DIV_WIDTH-1:0] row_div;
  logic [FW-1:0]        frame_cnt;
  logic [BW-1:0]        blank_cnt;
  logic [BW-1:0]        blank_cnt_next;

  // A load always wins over a terminal count, so the load cycle never ticks.
  assign row_tick   = enable && !div_load && (prescaler == (row_div - DIV_ONE));
  assign frame_tick = row_tick && (Seletor_Linhas == ROW_LAST);
  assign image_tick = frame_tick && (frame_cnt == FRAME_LAST);

  // Prescaler and divisor register; divisors below 2 are clamped to 2.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prescaler <= '0;
      row_div   <= DIV_RST;
    end else if (div_load) begin
      row_div   <= (div_in < DIV_MIN) ? DIV_MIN : div_in;
      prescaler <= '0;
    end else if (row_tick) begin
      prescaler <= '0;
    end else if (enable) begin
      prescaler <= prescaler + DIV_ONE;
    end
  end

  // Row selector wraps at ROWS, which need not be a power of two.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      Seletor_Linhas <= '0;
    end else if (row_tick) begin
      Seletor_Linhas <= (Seletor_Linhas == ROW_LAST) ? '0 : Seletor_Linhas + RW'(1);
    end
  end

  // Frame counter and image selector advance on frame ticks.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_cnt      <= '0;
      Seletor_imagem <= '0;
    end else if (frame_tick) begin
      if (image_tick) begin
        frame_cnt      <= '0;
        Seletor_imagem <= (Seletor_imagem == IMG_LAST) ? '0 : Seletor_imagem + IW'(1);
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // Blank countdown: reloads on every row tick, drains only while running.
  always_comb begin
    blank_cnt_next = blank_cnt;
    if (row_tick) begin
      blank_cnt_next = BLANK_INIT;
    end else if (enable && (blank_cnt != '0)) begin
      blank_cnt_next = blank_cnt - BW'(1);
    end
  end

  // Blank is registered from the next count so it rises with the row change.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      blank_cnt <= '0;
      blank     <= 1'b0;
    end else begin
      blank_cnt <= blank_cnt_next;
      blank     <= (blank_cnt_next != '0);
    end
  end

endmodule
